// File: rtl/cc1200_spi_responder_if.sv
// ---------------------------------------------------------------------------
// cc1200_spi_responder_if : four-wire SPI bus between a master and the responder
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

interface cc1200_spi_responder_if;
  logic SCLK;
  logic MOSI;
  logic CS_n;
  logic MISO;

  modport master (output SCLK, output MOSI, output CS_n, input MISO);
  modport slave  (input SCLK, input MOSI, input CS_n, output MISO);
endinterface

`default_nettype wire

// File: rtl/cc1200_spi_responder.sv
// ---------------------------------------------------------------------------
// cc1200_spi_responder : CC1200 SPI-side emulator (status, registers, TX stream, RX FIFO, GPIO3)
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module cc1200_spi_responder #(
  parameter int FIFO_DEPTH = 64,
  parameter int PKT_CYCLES = 1000
) (
  input  logic                   clk,
  input  logic                   rstn,
  cc1200_spi_responder_if.slave  spi,
  output logic                   GPIO3,
  output logic [7:0]             TxByte,
  output logic                   TxByteValid,
  input  logic [7:0]             RxLoadData,
  input  logic                   RxLoadValid,
  output logic                   RxLoadReady,
  input  logic                   RxPktStart,
  output logic [8:0]             RxLevel,
  output logic                   RxUnderflow
);

  localparam int         AW        = $clog2(FIFO_DEPTH);
  localparam int         CW        = $clog2(PKT_CYCLES);
  localparam logic [5:0] FIFO_ADDR = 6'h3F;
  localparam logic [7:0] TX_BURST  = 8'h7F;

  typedef enum logic [0:0] {PH_HDR = 1'b0, PH_DATA = 1'b1} phase_t;

  // Pin synchronizers and edge registers
  logic [1:0] sclk_sync, mosi_sync, cs_sync;
  logic       sclk_q, cs_q;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      sclk_sync <= 2'b00;
      mosi_sync <= 2'b00;
      cs_sync   <= 2'b11;
      sclk_q    <= 1'b0;
      cs_q      <= 1'b1;
    end else begin
      sclk_sync <= {sclk_sync[0], spi.SCLK};
      mosi_sync <= {mosi_sync[0], spi.MOSI};
      cs_sync   <= {cs_sync[0], spi.CS_n};
      sclk_q    <= sclk_sync[1];
      cs_q      <= cs_sync[1];
    end
  end

  logic sclk_s, mosi_s, cs_s;
  logic sclk_rise, sclk_fall, cs_fall, cs_rise;

  assign sclk_s    = sclk_sync[1];
  assign mosi_s    = mosi_sync[1];
  assign cs_s      = cs_sync[1];
  assign sclk_rise = sclk_s & ~sclk_q;
  assign sclk_fall = ~sclk_s & sclk_q;
  assign cs_fall   = ~cs_s & cs_q;
  assign cs_rise   = cs_s & ~cs_q;

  // Transaction state
  phase_t      phase;
  logic [7:0]  hdr;
  logic [5:0]  cur_addr;
  logic [2:0]  bit_cnt;
  logic [7:0]  rx_shift;
  logic [7:0]  tx_shift;
  logic        tx_seen;
  logic [7:0]  regs [16];

  // RX FIFO state
  logic [7:0]    fifo_mem [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic          fifo_empty;

  // Packet timer state
  logic [CW-1:0] pkt_cnt;
  logic          pkt_is_tx;

  logic       shift_en, byte_done;
  logic [7:0] rx_byte;
  logic [7:0] status_byte;
  logic [2:0] radio_state;

  assign shift_en    = sclk_rise & ~cs_s;
  assign byte_done   = shift_en & (bit_cnt == 3'd7);
  assign rx_byte     = {rx_shift[6:0], mosi_s};
  assign radio_state = GPIO3 ? (pkt_is_tx ? 3'b010 : 3'b001) : 3'b000;
  assign status_byte = {1'b0, radio_state, 4'hF};
  assign fifo_empty  = (RxLevel == 9'd0);
  assign spi.MISO    = tx_shift[7];

  // Decode of the byte that completes this cycle and what MISO carries next
  logic [7:0] hdr_n;
  logic [5:0] addr_n;
  logic       fifo_sel, fifo_rd;
  logic [7:0] load_byte;

  always_comb begin
    hdr_n  = hdr;
    addr_n = cur_addr;
    if (phase == PH_HDR) begin
      hdr_n  = rx_byte;
      addr_n = rx_byte[5:0];
    end else if (hdr[6]) begin
      addr_n = cur_addr + 6'd1;
    end
    fifo_sel  = (hdr_n[5:0] == FIFO_ADDR);
    fifo_rd   = byte_done & hdr_n[7] & fifo_sel;
    load_byte = status_byte;
    if (hdr_n[7]) begin
      if (fifo_sel)
        load_byte = fifo_empty ? 8'h00 : fifo_mem[rd_ptr];
      else if (addr_n < 6'h10)
        load_byte = regs[addr_n[3:0]];
      else
        load_byte = 8'h00;
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      phase       <= PH_HDR;
      hdr         <= 8'h00;
      cur_addr    <= 6'd0;
      bit_cnt     <= 3'd0;
      rx_shift    <= 8'h00;
      tx_shift    <= 8'h00;
      tx_seen     <= 1'b0;
      TxByte      <= 8'h00;
      TxByteValid <= 1'b0;
      for (int i = 0; i < 16; i++) regs[i] <= 8'h00;
    end else begin
      TxByteValid <= 1'b0;

      if (cs_rise) begin
        bit_cnt <= 3'd0;
        phase   <= PH_HDR;
        tx_seen <= 1'b0;
      end else if (shift_en) begin
        rx_shift <= rx_byte;
        bit_cnt  <= bit_cnt + 3'd1;
        if (byte_done) begin
          cur_addr <= addr_n;
          if (phase == PH_HDR) begin
            hdr   <= rx_byte;
            phase <= PH_DATA;
          end else if (!hdr[7]) begin
            if (hdr[5:0] == FIFO_ADDR) begin
              TxByte      <= rx_byte;
              TxByteValid <= 1'b1;
              if (hdr == TX_BURST) tx_seen <= 1'b1;
            end else if (cur_addr < 6'h10) begin
              regs[cur_addr[3:0]] <= rx_byte;
            end
          end
        end
      end

      // The falling edge that follows byte_done must not shift out the freshly loaded MSB
      if (cs_fall)
        tx_shift <= status_byte;
      else if (byte_done)
        tx_shift <= load_byte;
      else if (sclk_fall && !cs_s && bit_cnt != 3'd0)
        tx_shift <= {tx_shift[6:0], 1'b0};
    end
  end

  // RX FIFO
  logic       push, pop;
  logic [8:0] level_nxt;

  assign push      = RxLoadValid & RxLoadReady;
  assign pop       = fifo_rd & ~fifo_empty;
  assign level_nxt = RxLevel + 9'(push) - 9'(pop);

  always_ff @(posedge clk) begin
    if (push) fifo_mem[wr_ptr] <= RxLoadData;
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      RxLevel     <= 9'd0;
      RxLoadReady <= 1'b1;
      RxUnderflow <= 1'b0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      RxLevel     <= level_nxt;
      RxLoadReady <= (level_nxt != 9'(FIFO_DEPTH));
      if (fifo_rd && fifo_empty) RxUnderflow <= 1'b1;
    end
  end

  // Packet timer driving GPIO3
  logic tx_start;
  assign tx_start = cs_rise & tx_seen;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      GPIO3     <= 1'b0;
      pkt_cnt   <= '0;
      pkt_is_tx <= 1'b0;
    end else if (GPIO3) begin
      if (pkt_cnt == '0)
        GPIO3 <= 1'b0;
      else
        pkt_cnt <= pkt_cnt - CW'(1);
    end else if (tx_start || RxPktStart) begin
      GPIO3     <= 1'b1;
      pkt_cnt   <= CW'(PKT_CYCLES - 1);
      pkt_is_tx <= tx_start;
    end
  end

endmodule

`default_nettype wire
